uart_mult_byte_tx: RTL and testbench

Multi-byte UART packet transmitter, the transmit-side counterpart of uart_mult_byte_rx. It latches a payload of 1..MAX_BYTES bytes on a start pulse and frames it as HEAD, LEN, payload, CRC8. It serializes the frame LSB-first at 8N1 on uart_txd. It sits in the 50 MHz domain beside uart_protocol_tx and is driven by status/readback logic that reports to the host.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_byte_tx.sv | 100 ++++++++++
 rtl/uart_mult_byte_tx.sv | 144 ++++++++++++++
 tb/tb_uart_mult_byte_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divider derivation, framing constants and the
// byte-wise CRC8 step used by both the packet transmitter and receiver.
package uart_pkg;
   localparam logic [7:0] HEAD_BYTE_DEF = 8'h55;
   localparam logic [7:0] CRC8_POLY     = 8'h07;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;
   typedef enum logic [1:0] {PKT_IDLE, PKT_ARM, PKT_SEND, PKT_DONE} pkt_state_t;

   function automatic int bps_cnt_calc(input int clk_freq, input int uart_bps);
      return clk_freq / uart_bps;
   endfunction

   // MSB-first, init/xorout handled by the caller (init 0, no final XOR).
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer. A load during IDLE, or in the last STOP cycle,
// starts the next byte with no idle gap between bytes.
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int BPS_CNT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] din,
   output logic       txd,
   output logic       busy,
   output logic       done
);
   localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

   bit_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_reg, bit_next;
   logic [7:0]       shift_reg, shift_next;
   logic             txd_reg, txd_next;
   logic             cnt_last;

   assign cnt_last = (cnt_reg == CNT_LAST);
   assign busy     = (state_reg != IDLE);
   assign done     = (state_reg == STOP) && cnt_last;
   assign txd      = txd_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         bit_reg   <= 3'd0;
         shift_reg <= 8'h00;
         txd_reg   <= 1'b1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         txd_reg   <= txd_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + CNT_W'(1);
      bit_next   = bit_reg;
      shift_next = shift_reg;
      txd_next   = txd_reg;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (load) begin
               state_next = START;
               shift_next = din;
               txd_next   = 1'b0;
            end
         end
         START: begin
            if (cnt_last) begin
               state_next = DATA;
               cnt_next   = '0;
               bit_next   = 3'd0;
               txd_next   = shift_reg[0];
            end
         end
         DATA: begin
            if (cnt_last) begin
               cnt_next = '0;
               if (bit_reg == 3'd7) begin
                  state_next = STOP;
                  txd_next   = 1'b1;
               end else begin
                  // txd is registered, so present the following bit one shift ahead
                  bit_next   = bit_reg + 3'd1;
                  shift_next = shift_reg >> 1;
                  txd_next   = shift_reg[1];
               end
            end
         end
         STOP: begin
            if (cnt_last) begin
               cnt_next = '0;
               if (load) begin
                  state_next = START;
                  shift_next = din;
                  txd_next   = 1'b0;
               end else begin
                  state_next = IDLE;
                  txd_next   = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART packet transmitter: frames HEAD, LEN, payload, CRC8 and
// streams the bytes back-to-back through the single-byte serializer.
module uart_mult_byte_tx
   import uart_pkg::*;
#(
   parameter int         CLK_FREQ  = 50000000,
   parameter int         UART_BPS  = 115200,
   parameter int         MAX_BYTES = 11,
   parameter logic [7:0] HEAD_BYTE = HEAD_BYTE_DEF
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   pack_start,
   input  logic [7:0]             pack_len,
   input  logic [MAX_BYTES*8-1:0] pack_data,
   output logic                   uart_txd,
   output logic                   tx_busy,
   output logic                   pack_done,
   output logic                   pack_err,
   output logic [7:0]             tx_byte_cnt
);
   localparam int         BPS_CNT = bps_cnt_calc(CLK_FREQ, UART_BPS);
   localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);
   localparam int         IDX_W   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

   pkt_state_t             state_reg, state_next;
   logic [7:0]             len_reg, len_next;
   logic [MAX_BYTES*8-1:0] data_reg, data_next;
   logic [7:0]             crc_reg, crc_next;
   logic [7:0]             cnt_reg, cnt_next;
   logic                   err_reg, err_next;

   logic                   start_ok, more_bytes, is_payload;
   logic                   ser_load, ser_busy, ser_done;
   logic [7:0]             sel_idx, byte_sel;
   logic [IDX_W-1:0]       pay_idx;
   logic [7:0]             payload_bytes [2**IDX_W];

   genvar gi;
   generate
      for (gi = 0; gi < 2**IDX_W; gi++) begin : g_pay
         if (gi < MAX_BYTES) begin : g_real
            assign payload_bytes[gi] = data_reg[8*gi +: 8];
         end else begin : g_pad
            assign payload_bytes[gi] = 8'h00;
         end
      end
   endgenerate

   // The byte being selected is the one about to be loaded: HEAD while arming,
   // otherwise the byte after the one currently on the wire.
   assign start_ok   = (pack_len != 8'd0) && (pack_len <= MAX_LEN);
   assign sel_idx    = (state_reg == PKT_ARM) ? 8'd0 : cnt_reg + 8'd1;
   assign pay_idx    = IDX_W'(sel_idx - 8'd2);
   assign is_payload = (sel_idx >= 8'd2) && (sel_idx <= len_reg + 8'd1);
   assign more_bytes = (cnt_reg < len_reg + 8'd2);

   always_comb begin
      if (sel_idx == 8'd0)      byte_sel = HEAD_BYTE;
      else if (sel_idx == 8'd1) byte_sel = len_reg;
      else if (is_payload)      byte_sel = payload_bytes[pay_idx];
      else                      byte_sel = crc_reg;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_reg <= PKT_IDLE;
         len_reg   <= 8'd0;
         data_reg  <= '0;
         crc_reg   <= 8'h00;
         cnt_reg   <= 8'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         len_reg   <= len_next;
         data_reg  <= data_next;
         crc_reg   <= crc_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      data_next  = data_reg;
      crc_next   = crc_reg;
      cnt_next   = cnt_reg;
      err_next   = 1'b0;
      ser_load   = 1'b0;
      case (state_reg)
         PKT_IDLE: begin
            if (pack_start) begin
               if (start_ok) begin
                  state_next = PKT_ARM;
                  len_next   = pack_len;
                  data_next  = pack_data;
                  crc_next   = 8'h00;
                  cnt_next   = 8'd0;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         PKT_ARM: begin
            if (!ser_busy) begin
               ser_load   = 1'b1;
               state_next = PKT_SEND;
            end
         end
         PKT_SEND: begin
            if (ser_done) begin
               if (more_bytes) begin
                  ser_load = 1'b1;
                  cnt_next = cnt_reg + 8'd1;
                  if (is_payload) crc_next = crc8_byte(crc_reg, byte_sel);
               end else begin
                  state_next = PKT_DONE;
                  cnt_next   = 8'd0;
               end
            end
         end
         PKT_DONE: state_next = PKT_IDLE;
         default:  state_next = PKT_IDLE;
      endcase
   end

   assign tx_busy     = (state_reg == PKT_SEND);
   assign pack_done   = (state_reg == PKT_DONE);
   assign pack_err    = err_reg;
   assign tx_byte_cnt = cnt_reg;

   uart_byte_tx #(
      .BPS_CNT(BPS_CNT)
   ) u_byte_tx (
      .clk (sys_clk),
      .rst (sys_rst),
      .load(ser_load),
      .din (byte_sel),
      .txd (uart_txd),
      .busy(ser_busy),
      .done(ser_done)
   );
endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx: a wire-level UART receiver decodes uart_txd and
// each frame is compared with a frame list built from the packet format rules.
`timescale 1ns/1ps
module tb_uart_mult_byte_tx;
   localparam int CLK_FREQ = 50_000_000;
   localparam int UART_BPS = 5_000_000;
   localparam int BPS      = CLK_FREQ / UART_BPS;
   localparam int MAXB     = 11;

   logic              sys_clk    = 1'b0;
   logic              sys_rst    = 1'b1;
   logic              pack_start = 1'b0;
   logic [7:0]        pack_len   = 8'd0;
   logic [MAXB*8-1:0] pack_data  = '0;
   logic              uart_txd, tx_busy, pack_done, pack_err;
   logic [7:0]        tx_byte_cnt;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] rx_q[$];
   logic [7:0] cnt_q[$];
   logic [7:0] exp_q[$];

   uart_mult_byte_tx #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS),
      .MAX_BYTES(MAXB),
      .HEAD_BYTE(8'h55)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .pack_start (pack_start),
      .pack_len   (pack_len),
      .pack_data  (pack_data),
      .uart_txd   (uart_txd),
      .tx_busy    (tx_busy),
      .pack_done  (pack_done),
      .pack_err   (pack_err),
      .tx_byte_cnt(tx_byte_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [MAXB*8-1:0] rand_data();
      logic [MAXB*8-1:0] d;
      for (int i = 0; i < MAXB; i++) d[8*i +: 8] = 8'($urandom);
      return d;
   endfunction

   // Expected wire bytes; CRC computed bit-serially as polynomial division.
   task automatic build_exp(input int len, input logic [MAXB*8-1:0] d);
      logic [7:0] crc;
      logic [7:0] b;
      logic       fb;
      crc = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'h55);
      exp_q.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
         b = d[8*i +: 8];
         exp_q.push_back(b);
         for (int k = 7; k >= 0; k--) begin
            fb  = crc[7] ^ b[k];
            crc = {crc[6:0], 1'b0};
            if (fb) crc = crc ^ 8'h07;
         end
      end
      exp_q.push_back(crc);
   endtask

   // Wire receiver: samples each bit in the middle of its BPS-cycle slot.
   initial begin : monitor
      bit         active;
      logic       prev;
      int         t;
      int         slot;
      logic [7:0] sh;
      active = 1'b0;
      prev   = 1'b1;
      t      = 0;
      sh     = 8'h00;
      forever begin
         @(negedge sys_clk);
         if (sys_rst) begin
            active = 1'b0;
            prev   = 1'b1;
         end else if (!active) begin
            if (prev && !uart_txd) begin
               active = 1'b1;
               t      = 0;
            end
            prev = uart_txd;
         end else begin
            t++;
            if (t % BPS == BPS / 2) begin
               slot = t / BPS;
               if (slot == 0) begin
                  check_eq("start_bit", uart_txd, 0);
                  cnt_q.push_back(tx_byte_cnt);
               end else if (slot <= 8) begin
                  sh[slot-1] = uart_txd;
               end else begin
                  check_eq("stop_bit", uart_txd, 1);
                  rx_q.push_back(sh);
                  active = 1'b0;
                  prev   = 1'b1;
               end
            end
         end
      end
   end

   // Caller is at a negedge. act_kind 1: second start at act_cycle; 2: reset at act_cycle.
   task automatic run_frame(input int len, input logic [MAXB*8-1:0] d, input int act_cycle, input int act_kind);
      int cyc, bound, frame_cycles, busy_gaps, err_seen, done_hits, low_hits;
      cyc = 0; busy_gaps = 0; err_seen = 0; done_hits = 0; low_hits = 0;
      frame_cycles = (len + 3) * 10 * BPS;
      bound        = frame_cycles + 40;
      build_exp(len, d);
      rx_q.delete();
      cnt_q.delete();
      pack_start = 1'b1;
      pack_len   = 8'(len);
      pack_data  = d;
      @(negedge sys_clk);
      pack_start = 1'b0;
      check_eq("txd_at_k", uart_txd, 1);
      check_eq("busy_at_k", tx_busy, 0);
      while (!pack_done && cyc < bound) begin
         @(negedge sys_clk);
         cyc++;
         pack_start = 1'b0;
         if (cyc == 1) begin
            check_eq("txd_at_k1", uart_txd, 0);
            check_eq("busy_at_k1", tx_busy, 1);
         end
         if (!pack_done && !tx_busy) busy_gaps++;
         if (pack_err) err_seen++;
         if (cyc == act_cycle && act_kind == 1) begin
            pack_start = 1'b1;
            pack_len   = 8'd3;
            pack_data  = ~d;
         end
         if (cyc == act_cycle && act_kind == 2) begin
            check_eq("txd_before_rst", uart_txd, 0);
            #2 sys_rst = 1'b1;
            #1;
            check_eq("rst_txd_async", uart_txd, 1);
            check_eq("rst_busy_async", tx_busy, 0);
            repeat (3) begin
               @(negedge sys_clk);
               if (pack_done) done_hits++;
               if (!uart_txd) low_hits++;
            end
            sys_rst = 1'b0;
            repeat (5) begin
               @(negedge sys_clk);
               if (pack_done) done_hits++;
               if (!uart_txd) low_hits++;
            end
            check_eq("no_done_after_rst", done_hits, 0);
            check_eq("txd_high_after_rst", low_hits, 0);
            check_eq("cnt_zero_after_rst", tx_byte_cnt, 0);
            $display("abort len=%0d at cycle %0d", len, cyc);
            return;
         end
      end
      check_eq("done_cycle", cyc, frame_cycles + 1);
      check_eq("busy_low_at_done", tx_busy, 0);
      check_eq("cnt_zero_at_done", tx_byte_cnt, 0);
      check_eq("busy_gaps", busy_gaps, 0);
      check_eq("err_during_frame", err_seen, 0);
      @(negedge sys_clk);
      check_eq("done_one_cycle", pack_done, 0);
      check_eq("txd_idle_after", uart_txd, 1);
      check_eq("rx_count", rx_q.size(), len + 3);
      for (int i = 0; i < len + 3; i++) begin
         if (i < rx_q.size()) check_eq($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
         if (i < cnt_q.size()) check_eq($sformatf("byte_cnt%0d", i), cnt_q[i], i);
      end
      $display("frame len=%0d crc=%02h rx_bytes=%0d done_at=%0d", len, exp_q[len+2], rx_q.size(), cyc);
   endtask

   task automatic run_bad(input int len);
      int err_hits, busy_hits, low_hits;
      err_hits = 0; busy_hits = 0; low_hits = 0;
      pack_start = 1'b1;
      pack_len   = 8'(len);
      pack_data  = rand_data();
      @(negedge sys_clk);
      pack_start = 1'b0;
      check_eq("err_pulse", pack_err, 1);
      repeat (6) begin
         @(negedge sys_clk);
         if (pack_err) err_hits++;
         if (tx_busy) busy_hits++;
         if (!uart_txd) low_hits++;
      end
      check_eq("err_single", err_hits, 0);
      check_eq("err_busy", busy_hits, 0);
      check_eq("err_txd", low_hits, 0);
      $display("reject len=%0d", len);
   endtask

   initial begin : main
      logic [MAXB*8-1:0] d;
      sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      check_eq("rst_txd", uart_txd, 1);
      check_eq("rst_busy", tx_busy, 0);
      check_eq("rst_done", pack_done, 0);
      check_eq("rst_err", pack_err, 0);
      check_eq("rst_cnt", tx_byte_cnt, 0);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      d = rand_data();
      d[7:0] = 8'h01;
      run_frame(1, d, 0, 0);
      check_eq("t1_crc", (rx_q.size() > 3) ? {24'd0, rx_q[3]} : 32'hFFFF_FFFF, 32'h07);

      d = rand_data();
      for (int i = 0; i < 9; i++) d[8*i +: 8] = 8'h31 + 8'(i);
      run_frame(9, d, 0, 0);
      check_eq("t2_crc", (rx_q.size() > 11) ? {24'd0, rx_q[11]} : 32'hFFFF_FFFF, 32'hF4);

      run_bad(0);
      run_bad(12);
      repeat (3) run_bad($urandom_range(13, 255));

      run_frame(5, rand_data(), 25 * BPS, 1);

      d = rand_data();
      d[15:8] = 8'h00;
      run_frame(4, d, 1 + 34 * BPS + 3, 2);
      run_frame(4, rand_data(), 0, 0);

      d = rand_data();
      d[7:0] = 8'h00;
      run_frame(1, d, 0, 0);

      repeat (8) begin
         repeat ($urandom_range(0, 5)) @(negedge sys_clk);
         run_frame($urandom_range(1, MAXB), rand_data(), 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
